// File: rtl/traffic_pkg.sv
// Shared phase codes and width helper for the signal-phase sequencer,
// the lamp driver and the display logic.
package traffic_pkg;

   typedef enum logic [2:0] {
      PH_OFF    = 3'd0,
      PH_LEFT   = 3'd1,
      PH_FWD    = 3'd2,
      PH_RIGHT  = 3'd3,
      PH_YELLOW = 3'd4,
      PH_ALLRED = 3'd5,
      PH_WALK   = 3'd6,
      PH_FLASH  = 3'd7
   } phase_e;

   // Approach-index width; a single approach still needs one bit.
   function automatic int dir_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; only moves on the tick strobe
// and never goes below one while counting.
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic [CNT_W-1:0] value,
   output logic             expire
);

   logic [CNT_W-1:0] value_q;

   // Clear wins over load, load wins over counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else if (clr) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= load_val;
      end else if (tick && (value_q > CNT_W'(1))) begin
         value_q <= value_q - CNT_W'(1);
      end else begin
         value_q <= value_q;
      end
   end

   assign value  = value_q;
   assign expire = tick && (value_q <= CNT_W'(1));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-approach signal-phase sequencer with pedestrian walk insertion and
// flashing-yellow maintenance mode.
module traffic_phase_sequencer
   import traffic_pkg::*;
#(
   parameter int N_DIR    = 2,
   parameter int CNT_W    = 8,
   parameter int FWD_T    = 15,
   parameter int RIGHT_T  = 10,
   parameter int LEFT_T   = 10,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 1,
   parameter int PED_T    = 8,
   localparam int DIR_W   = dir_width(N_DIR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             halt,
   input  logic             flash_mode,
   input  logic             ped_req,
   output logic [2:0]       phase,
   output logic [DIR_W-1:0] dir,
   output logic [CNT_W-1:0] counter,
   output logic             ped_pending,
   output logic             flash_on
);

   localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(N_DIR - 1);

   if (N_DIR < 1) begin : g_bad_ndir
      $error("N_DIR must be at least 1");
   end
   if (FWD_T < 1 || FWD_T >= 2**CNT_W || RIGHT_T < 1 || RIGHT_T >= 2**CNT_W ||
       LEFT_T < 1 || LEFT_T >= 2**CNT_W || YELLOW_T < 1 || YELLOW_T >= 2**CNT_W ||
       ALLRED_T < 1 || ALLRED_T >= 2**CNT_W || PED_T < 1 || PED_T >= 2**CNT_W) begin : g_bad_dur
      $error("phase durations must lie in 1 .. 2**CNT_W-1");
   end

   phase_e           phase_q, phase_d;
   logic [DIR_W-1:0] dir_q, dir_d;
   logic             ped_q, ped_d;
   logic             flash_q, flash_d;
   logic             tmr_clr, tmr_load, tmr_expire, walk_entry;
   logic [CNT_W-1:0] tmr_val, tmr_value;

   function automatic logic [CNT_W-1:0] dur(input phase_e p);
      case (p)
         PH_FWD:    dur = CNT_W'(FWD_T);
         PH_RIGHT:  dur = CNT_W'(RIGHT_T);
         PH_LEFT:   dur = CNT_W'(LEFT_T);
         PH_YELLOW: dur = CNT_W'(YELLOW_T);
         PH_ALLRED: dur = CNT_W'(ALLRED_T);
         PH_WALK:   dur = CNT_W'(PED_T);
         default:   dur = '0;
      endcase
   endfunction

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tick     (tick),
      .value    (tmr_value),
      .expire   (tmr_expire)
   );

   // Next-state selection: halt, then flash, then normal sequencing.
   always_comb begin
      phase_d    = phase_q;
      dir_d      = dir_q;
      flash_d    = flash_q;
      tmr_clr    = 1'b0;
      tmr_load   = 1'b0;
      walk_entry = 1'b0;
      if (halt) begin
         phase_d = PH_OFF;
         dir_d   = '0;
         flash_d = 1'b0;
         tmr_clr = 1'b1;
      end else if (flash_mode) begin
         phase_d = PH_FLASH;
         tmr_clr = 1'b1;
         if (phase_q != PH_FLASH) begin
            flash_d = 1'b1;
         end else begin
            flash_d = flash_q ^ tick;
         end
      end else if (phase_q == PH_FLASH) begin
         // Parking on the last approach makes the resume land on approach 0.
         phase_d  = PH_ALLRED;
         dir_d    = DIR_LAST;
         flash_d  = 1'b0;
         tmr_load = 1'b1;
      end else if (tmr_expire) begin
         tmr_load = 1'b1;
         case (phase_q)
            PH_OFF:    phase_d = PH_FWD;
            PH_FWD:    phase_d = PH_RIGHT;
            PH_RIGHT:  phase_d = PH_LEFT;
            PH_LEFT:   phase_d = PH_YELLOW;
            PH_YELLOW: phase_d = PH_ALLRED;
            PH_ALLRED: begin
               if (ped_q) begin
                  phase_d    = PH_WALK;
                  walk_entry = 1'b1;
               end else begin
                  phase_d = PH_FWD;
                  dir_d   = (dir_q == DIR_LAST) ? '0 : dir_q + DIR_W'(1);
               end
            end
            PH_WALK: begin
               phase_d = PH_FWD;
               dir_d   = (dir_q == DIR_LAST) ? '0 : dir_q + DIR_W'(1);
            end
            default:   phase_d = PH_OFF;
         endcase
      end else begin
         phase_d = phase_q;
      end
      tmr_val = dur(phase_d);

      // Requests arriving while walk is active or starting are dropped.
      if (walk_entry) begin
         ped_d = 1'b0;
      end else if (ped_req && (phase_q != PH_WALK)) begin
         ped_d = 1'b1;
      end else begin
         ped_d = ped_q;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= PH_OFF;
         dir_q   <= '0;
         ped_q   <= 1'b0;
         flash_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         dir_q   <= dir_d;
         ped_q   <= ped_d;
         flash_q <= flash_d;
      end
   end

   assign phase       = phase_q;
   assign dir         = dir_q;
   assign counter     = tmr_value;
   assign ped_pending = ped_q;
   assign flash_on    = flash_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scenario bench for traffic_phase_sequencer: a reference model pushes the
// expected output vector per driven clock, compared after each edge.
module tb_traffic_phase_sequencer;

   localparam int N_DIR = 2;
   localparam int CNT_W = 8;
   localparam int DIR_W = 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             tick = 1'b0, halt = 1'b0, flash_mode = 1'b0, ped_req = 1'b0;
   logic [2:0]       phase;
   logic [DIR_W-1:0] dir;
   logic [CNT_W-1:0] counter;
   logic             ped_pending, flash_on;

   int total = 0;
   int bad   = 0;

   logic [13:0] sb_q[$];

   logic [2:0] m_phase;
   int         m_dir, m_cnt;
   logic       m_ped, m_fl;

   traffic_phase_sequencer #(
      .N_DIR(N_DIR), .CNT_W(CNT_W), .FWD_T(3), .RIGHT_T(2), .LEFT_T(2),
      .YELLOW_T(1), .ALLRED_T(1), .PED_T(2)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .halt(halt), .flash_mode(flash_mode),
      .ped_req(ped_req), .phase(phase), .dir(dir), .counter(counter),
      .ped_pending(ped_pending), .flash_on(flash_on)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] obs();
      return {phase, dir, counter, ped_pending, flash_on};
   endfunction

   function automatic logic [2:0] nxt_phase(input logic [2:0] p);
      case (p)
         3'd0: return 3'd2;
         3'd2: return 3'd3;
         3'd3: return 3'd1;
         3'd1: return 3'd4;
         3'd4: return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic int dur_of(input logic [2:0] p);
      case (p)
         3'd2: return 3;
         3'd3: return 2;
         3'd1: return 2;
         3'd4: return 1;
         3'd5: return 1;
         3'd6: return 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 3'd0; m_dir = 0; m_cnt = 0; m_ped = 1'b0; m_fl = 1'b0;
   endtask

   task automatic model_step(input logic t, input logic h, input logic f, input logic p);
      logic [2:0] n_phase = m_phase;
      int         n_dir = m_dir, n_cnt = m_cnt;
      logic       n_ped = m_ped, n_fl = m_fl;
      bit         walk_in = 1'b0;
      if (h) begin
         n_phase = 3'd0; n_dir = 0; n_cnt = 0; n_fl = 1'b0;
      end else if (f) begin
         n_phase = 3'd7; n_cnt = 0;
         n_fl = (m_phase == 3'd7) ? (m_fl ^ t) : 1'b1;
      end else if (m_phase == 3'd7) begin
         n_phase = 3'd5; n_cnt = 1; n_fl = 1'b0; n_dir = N_DIR - 1;
      end else if (t && m_cnt > 1) begin
         n_cnt = m_cnt - 1;
      end else if (t) begin
         if (m_phase == 3'd5 && m_ped) begin
            n_phase = 3'd6; walk_in = 1'b1;
         end else if (m_phase == 3'd5 || m_phase == 3'd6) begin
            n_phase = 3'd2; n_dir = (m_dir + 1) % N_DIR;
         end else begin
            n_phase = nxt_phase(m_phase);
         end
         n_cnt = dur_of(n_phase);
      end
      if (walk_in) n_ped = 1'b0;
      else if (p && m_phase != 3'd6) n_ped = 1'b1;
      m_phase = n_phase; m_dir = n_dir; m_cnt = n_cnt; m_ped = n_ped; m_fl = n_fl;
   endtask

   task automatic drive(input logic t, input logic h, input logic f, input logic p);
      tick = t; halt = h; flash_mode = f; ped_req = p;
      model_step(t, h, f, p);
      sb_q.push_back({m_phase, DIR_W'(m_dir), CNT_W'(m_cnt), m_ped, m_fl});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (obs() !== 14'd0) begin
         bad++; $display("FAIL reset_values got=%h want=%h", obs(), 14'd0);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_sequence();
      int exp_ph[19]  = '{2,2,2,3,3,1,1,4,5,2,2,2,3,3,1,1,4,5,2};
      int exp_dir[19] = '{0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,0};
      int exp_cnt[19] = '{3,2,1,2,1,2,1,1,1,3,2,1,2,1,2,1,1,1,3};
      logic [13:0] want;
      for (int i = 0; i < 19; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         want = sb_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++; $display("FAIL seq_sb step=%0d got=%h want=%h", i, obs(), want);
         end
         total++;
         if (phase !== 3'(exp_ph[i]) || dir !== DIR_W'(exp_dir[i]) || counter !== CNT_W'(exp_cnt[i])) begin
            bad++;
            $display("FAIL seq_table step=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                     i, phase, dir, counter, exp_ph[i], exp_dir[i], exp_cnt[i]);
         end
      end
   endtask

   task automatic test_ped_pulse();
      logic [13:0] want;
      bit found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL ped_pre got=%h want=%h", obs(), want); end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      want = sb_q.pop_front(); total++;
      if (obs() !== want) begin bad++; $display("FAIL ped_req_clk got=%h want=%h", obs(), want); end
      total++;
      if (phase !== 3'd3 || ped_pending !== 1'b1) begin
         bad++; $display("FAIL ped_latch got=%0d/%0d want=3/1", phase, ped_pending);
      end
      for (int i = 0; i < 12 && !found; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL ped_run got=%h want=%h", obs(), want); end
         found = (phase == 3'd6);
      end
      total++;
      if (!found || counter !== 8'd2 || ped_pending !== 1'b0 || dir !== 1'b0) begin
         bad++; $display("FAIL walk_entry got=%0d/%0d/%0d want=6/2/0", phase, counter, ped_pending);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      want = sb_q.pop_front(); total++;
      if (obs() !== want || phase !== 3'd6 || counter !== 8'd1) begin
         bad++; $display("FAIL walk_second got=%h want=%h", obs(), want);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      want = sb_q.pop_front(); total++;
      if (obs() !== want || phase !== 3'd2 || dir !== 1'b1 || counter !== 8'd3) begin
         bad++; $display("FAIL walk_exit got=%0d/%0d/%0d want=2/1/3", phase, dir, counter);
      end
   endtask

   task automatic test_ped_hold();
      logic [13:0] want;
      logic [2:0]  prev;
      bit found = 1'b0;
      int walks = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL hold_pre got=%h want=%h", obs(), want); end
         found = (phase == 3'd6);
      end
      total++;
      if (!found) begin bad++; $display("FAIL hold_timeout got=%0d want=6", phase); end
      walks = 1;
      prev = phase;
      for (int i = 1; i < 44; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL hold_sb got=%h want=%h", obs(), want); end
         if (phase == 3'd6 && prev != 3'd6) begin
            walks++;
            total++;
            if (ped_pending !== 1'b0) begin
               bad++; $display("FAIL hold_drop got=%0d want=0", ped_pending);
            end
         end
         prev = phase;
      end
      total++;
      if (walks != 4) begin bad++; $display("FAIL hold_walks got=%0d want=4", walks); end
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL hold_drain got=%h want=%h", obs(), want); end
      end
   endtask

   task automatic test_halt();
      logic [13:0] want;
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL halt_pre got=%h want=%h", obs(), want); end
         found = (phase == 3'd1 && dir == 1'b1 && counter == 8'd2);
      end
      total++;
      if (!found) begin bad++; $display("FAIL halt_timeout got=%0d want=1", phase); end
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      want = sb_q.pop_front(); total++;
      if (obs() !== want || phase !== 3'd0 || counter !== 8'd0 || dir !== 1'b0) begin
         bad++; $display("FAIL halt_off got=%0d/%0d/%0d want=0/0/0", phase, dir, counter);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      want = sb_q.pop_front(); total++;
      if (obs() !== want || phase !== 3'd2 || counter !== 8'd3 || dir !== 1'b0) begin
         bad++; $display("FAIL halt_release got=%0d/%0d/%0d want=2/0/3", phase, dir, counter);
      end
   endtask

   task automatic test_flash();
      logic [13:0] want;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0);
         want = sb_q.pop_front(); total++;
         if (obs() !== want || phase !== 3'd7 || counter !== 8'd0 || flash_on !== ((i % 2) == 0)) begin
            bad++; $display("FAIL flash_step i=%0d got=%0d/%0d/%0d want=7/0/%0d",
                            i, phase, counter, flash_on, (i % 2) == 0);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      want = sb_q.pop_front(); total++;
      if (obs() !== want || phase !== 3'd5 || counter !== 8'd1 || dir !== 1'b1 || flash_on !== 1'b0) begin
         bad++; $display("FAIL flash_exit got=%0d/%0d/%0d want=5/1/1", phase, dir, counter);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      want = sb_q.pop_front(); total++;
      if (obs() !== want || phase !== 3'd2 || dir !== 1'b0 || counter !== 8'd3) begin
         bad++; $display("FAIL flash_resume got=%0d/%0d/%0d want=2/0/3", phase, dir, counter);
      end
   endtask

   task automatic test_slow_tick();
      logic [13:0] want;
      logic [CNT_W-1:0] prev;
      for (int i = 0; i < 40; i++) begin
         prev = counter;
         drive((i % 4) == 0, 1'b0, 1'b0, 1'b0);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL slow_sb i=%0d got=%h want=%h", i, obs(), want); end
         if ((i % 4) != 0) begin
            total++;
            if (counter !== prev) begin
               bad++; $display("FAIL slow_hold i=%0d got=%0d want=%0d", i, counter, prev);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [13:0] want;
      bit found = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      want = sb_q.pop_front(); total++;
      if (obs() !== want) begin bad++; $display("FAIL ar_req got=%h want=%h", obs(), want); end
      for (int i = 0; i < 30 && !found; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         want = sb_q.pop_front(); total++;
         if (obs() !== want) begin bad++; $display("FAIL ar_pre got=%h want=%h", obs(), want); end
         found = (phase == 3'd6);
      end
      total++;
      if (!found) begin bad++; $display("FAIL ar_timeout got=%0d want=6", phase); end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (obs() !== 14'd0) begin
         bad++; $display("FAIL async_reset got=%h want=%h", obs(), 14'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_ped_pulse();
      test_ped_hold();
      test_halt();
      test_flash();
      test_slow_tick();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
